// File: rtl/soc_run_monitor.sv
// Run supervisor for the SoC: drives fetch enable, watches PC / completion flag,
// and latches a pass / fail / timeout / stall verdict plus a fault-pulse count.
module soc_run_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 2000,
    parameter int unsigned STALL_CYCLES   = 64,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [31:0]          expected_i,
    input  logic [31:0]          instr_addr_i,
    input  logic [31:0]          mem_flag_i,
    input  logic [31:0]          mem_result_i,
    input  logic                 error_i,
    output logic                 fetch_enable_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 timeout_o,
    output logic                 stall_o,
    output logic [31:0]          result_o,
    output logic [31:0]          cycles_o,
    output logic [ERR_CNT_W-1:0] fault_cnt_o
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0]     STALL_LAST   = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE      = CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] FAULT_ONE    = ERR_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     last_addr_q;
    logic [CNT_W-1:0]     cycles_q;
    logic [CNT_W-1:0]     stall_cnt_q;
    logic [CNT_W-1:0]     result_q;
    logic [ERR_CNT_W-1:0] fault_cnt_q;
    logic                 err_q;
    logic                 fetch_q;
    logic                 done_q;
    logic                 pass_q;
    logic                 timeout_q;
    logic                 stall_q;

    logic                 addr_same;
    logic                 flag_hit;
    logic                 stall_hit;
    logic                 timeout_hit;
    logic [CNT_W-1:0]     cycles_d;
    logic [CNT_W-1:0]     stall_cnt_d;
    logic [ERR_CNT_W-1:0] fault_cnt_d;

    // Saturating counter updates and termination conditions for the current RUN cycle
    always_comb begin
        addr_same   = (instr_addr_i == last_addr_q);
        flag_hit    = (mem_flag_i != '0);
        stall_hit   = addr_same && (stall_cnt_q == STALL_LAST);
        timeout_hit = (cycles_q == TIMEOUT_LAST);
        cycles_d    = (cycles_q == '1) ? cycles_q : cycles_q + CNT_ONE;
        stall_cnt_d = addr_same ? stall_cnt_q + CNT_ONE : '0;
        fault_cnt_d = fault_cnt_q;
        if (error_i && !err_q && (fault_cnt_q != '1)) begin
            fault_cnt_d = fault_cnt_q + FAULT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            last_addr_q <= '0;
            cycles_q    <= '0;
            stall_cnt_q <= '0;
            result_q    <= '0;
            fault_cnt_q <= '0;
            err_q       <= 1'b0;
            fetch_q     <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            // Edge detector and address history track in every state
            err_q       <= error_i;
            last_addr_q <= instr_addr_i;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q     <= RUN;
                        fetch_q     <= 1'b1;
                        cycles_q    <= '0;
                        stall_cnt_q <= '0;
                        result_q    <= '0;
                        fault_cnt_q <= '0;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        stall_q     <= 1'b0;
                    end
                end
                RUN: begin
                    cycles_q    <= cycles_d;
                    stall_cnt_q <= stall_cnt_d;
                    fault_cnt_q <= fault_cnt_d;
                    if (flag_hit) begin
                        result_q <= mem_result_i;
                        pass_q   <= (mem_result_i == expected_i);
                        done_q   <= 1'b1;
                        fetch_q  <= 1'b0;
                        state_q  <= DONE;
                    end else if (stall_hit) begin
                        stall_q <= 1'b1;
                        done_q  <= 1'b1;
                        fetch_q <= 1'b0;
                        state_q <= DONE;
                    end else if (timeout_hit) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        fetch_q   <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fetch_enable_o = fetch_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign timeout_o      = timeout_q;
    assign stall_o        = stall_q;
    assign result_o       = result_q;
    assign cycles_o       = cycles_q;
    assign fault_cnt_o    = fault_cnt_q;

endmodule

// File: tb/tb_soc_run_monitor.sv
// Directed bench for soc_run_monitor: pass, wrong result, stall, timeout with
// faults, flag/timeout priority, mid-run reset and restart.
module tb_soc_run_monitor;

    localparam int unsigned ERR_CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic                 start_i;
    logic [31:0]          expected_i;
    logic [31:0]          instr_addr_i;
    logic [31:0]          mem_flag_i;
    logic [31:0]          mem_result_i;
    logic                 error_i;
    logic                 fetch_enable_o;
    logic                 done_o;
    logic                 pass_o;
    logic                 timeout_o;
    logic                 stall_o;
    logic [31:0]          result_o;
    logic [31:0]          cycles_o;
    logic [ERR_CNT_W-1:0] fault_cnt_o;

    int checks   = 0;
    int failures = 0;

    soc_run_monitor #(
        .TIMEOUT_CYCLES(100),
        .STALL_CYCLES  (8),
        .ERR_CNT_W     (ERR_CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .expected_i    (expected_i),
        .instr_addr_i  (instr_addr_i),
        .mem_flag_i    (mem_flag_i),
        .mem_result_i  (mem_result_i),
        .error_i       (error_i),
        .fetch_enable_o(fetch_enable_o),
        .done_o        (done_o),
        .pass_o        (pass_o),
        .timeout_o     (timeout_o),
        .stall_o       (stall_o),
        .result_o      (result_o),
        .cycles_o      (cycles_o),
        .fault_cnt_o   (fault_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start_i      = 1'b1;
        instr_addr_i = 32'hF000;
        mem_flag_i   = '0;
        error_i      = 1'b0;
        tick();
        start_i = 1'b0;
    endtask

    // Run RUN cycles first..last with an incrementing address and no flag
    task automatic run_plain(input int first, input int last, input logic [31:0] base);
        for (int k = first; k <= last; k++) begin
            instr_addr_i = base + 32'(4 * k);
            tick();
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        expected_i   = '0;
        instr_addr_i = '0;
        mem_flag_i   = '0;
        mem_result_i = '0;
        error_i      = 1'b0;
        tick();
        tick();
        chk("rst_fetch", 32'(fetch_enable_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_cycles", cycles_o, 0);
        chk("rst_fault", 32'(fault_cnt_o), 0);
        rst_ni = 1'b1;
        tick();
        chk("idle_fetch", 32'(fetch_enable_o), 0);

        // Normal pass
        do_start();
        chk("start_fetch", 32'(fetch_enable_o), 1);
        chk("start_cycles", cycles_o, 0);
        run_plain(1, 29, 32'h0);
        chk("pass_c29_done", 32'(done_o), 0);
        chk("pass_c29_cycles", cycles_o, 29);
        instr_addr_i = 32'(4 * 30);
        mem_flag_i   = 32'd1;
        mem_result_i = 32'd55;
        expected_i   = 32'd55;
        tick();
        mem_flag_i = '0;
        chk("pass_done", 32'(done_o), 1);
        chk("pass_pass", 32'(pass_o), 1);
        chk("pass_result", result_o, 55);
        chk("pass_cycles", cycles_o, 30);
        chk("pass_fetch", 32'(fetch_enable_o), 0);
        chk("pass_timeout", 32'(timeout_o), 0);
        tick();
        tick();
        chk("done_hold_cycles", cycles_o, 30);
        chk("done_hold_done", 32'(done_o), 1);

        // Wrong result, restarted from DONE
        do_start();
        chk("restart_done", 32'(done_o), 0);
        chk("restart_pass", 32'(pass_o), 0);
        chk("restart_result", result_o, 0);
        run_plain(1, 29, 32'h0);
        instr_addr_i = 32'(4 * 30);
        mem_flag_i   = 32'd1;
        mem_result_i = 32'd54;
        expected_i   = 32'd55;
        tick();
        mem_flag_i = '0;
        chk("wrong_done", 32'(done_o), 1);
        chk("wrong_pass", 32'(pass_o), 0);
        chk("wrong_timeout", 32'(timeout_o), 0);
        chk("wrong_stall", 32'(stall_o), 0);
        chk("wrong_result", result_o, 54);

        // Stall: address reaches 0x40 in cycle 9, stays there from cycle 10
        do_start();
        run_plain(1, 9, 32'd28);
        instr_addr_i = 32'h40;
        for (int k = 10; k <= 16; k++) tick();
        chk("stall_c16_done", 32'(done_o), 0);
        tick();
        chk("stall_stall", 32'(stall_o), 1);
        chk("stall_done", 32'(done_o), 1);
        chk("stall_cycles", cycles_o, 17);
        chk("stall_pass", 32'(pass_o), 0);
        chk("stall_timeout", 32'(timeout_o), 0);

        // Timeout with two 2-cycle error pulses
        do_start();
        for (int k = 1; k <= 100; k++) begin
            instr_addr_i = 32'h2000 + 32'(4 * k);
            error_i      = (k == 10 || k == 11 || k == 60 || k == 61);
            if (k == 100) chk("to_c99_done", 32'(done_o), 0);
            tick();
        end
        error_i = 1'b0;
        chk("to_timeout", 32'(timeout_o), 1);
        chk("to_done", 32'(done_o), 1);
        chk("to_cycles", cycles_o, 100);
        chk("to_fault", 32'(fault_cnt_o), 2);
        chk("to_stall", 32'(stall_o), 0);
        chk("to_pass", 32'(pass_o), 0);
        error_i = 1'b1;
        tick();
        error_i = 1'b0;
        tick();
        chk("done_fault_hold", 32'(fault_cnt_o), 2);

        // Flag in the timeout cycle wins
        do_start();
        run_plain(1, 99, 32'h3000);
        instr_addr_i = 32'h3000 + 32'(4 * 100);
        mem_flag_i   = 32'hABCD;
        mem_result_i = 32'd7;
        expected_i   = 32'd7;
        tick();
        mem_flag_i = '0;
        chk("prio_done", 32'(done_o), 1);
        chk("prio_pass", 32'(pass_o), 1);
        chk("prio_timeout", 32'(timeout_o), 0);
        chk("prio_cycles", cycles_o, 100);
        chk("prio_result", result_o, 7);

        // Mid-run reset, then clean restart; start during RUN is ignored
        do_start();
        run_plain(1, 19, 32'h4000);
        instr_addr_i = 32'h4000 + 32'(4 * 20);
        rst_ni       = 1'b0;
        tick();
        chk("mrst_fetch", 32'(fetch_enable_o), 0);
        chk("mrst_cycles", cycles_o, 0);
        chk("mrst_done", 32'(done_o), 0);
        chk("mrst_result", result_o, 0);
        rst_ni = 1'b1;
        tick();
        chk("mrst_idle_fetch", 32'(fetch_enable_o), 0);
        do_start();
        run_plain(1, 1, 32'h5000);
        chk("rerun_cycles", cycles_o, 1);
        chk("rerun_fetch", 32'(fetch_enable_o), 1);
        start_i      = 1'b1;
        instr_addr_i = 32'h5000 + 32'(4 * 2);
        tick();
        start_i = 1'b0;
        chk("start_in_run", cycles_o, 2);
        instr_addr_i = 32'h5000 + 32'(4 * 3);
        mem_flag_i   = 32'd1;
        mem_result_i = 32'd9;
        expected_i   = 32'd9;
        tick();
        mem_flag_i = '0;
        chk("rerun_done", 32'(done_o), 1);
        chk("rerun_end_cycles", cycles_o, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_run_monitor.md
# soc_run_monitor

Run supervisor placed directly downstream of the fault-tolerant `soc` top. It drives the SoC fetch enable, watches the program counter and the memory-mapped completion flag/result the SoC produces, and reports a registered verdict: pass, fail (wrong result), timeout, or stall. While the run is active it also counts injected error pulses, so fault-injection campaigns get a self-checking end-of-run summary without bench-side polling.

## Interface
- `TIMEOUT_CYCLES`, default 2000: maximum RUN cycles before a timeout verdict; legal range is ≥ 2.
- `STALL_CYCLES`, default 64: consecutive cycles with an unchanged `instr_addr_i` that declare a lockup; legal range is ≥ 2.
- `ERR_CNT_W`, default 8: width of the fault-pulse counter.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `start_i`  in  1  single-cycle pulse that begins a run; accepted in IDLE or DONE, ignored in RUN.
- `expected_i`  in  32  golden result; sampled in the terminating cycle.
- `instr_addr_i`  in  32  SoC core-0 instruction address (`instr_addr_o_0`).
- `mem_flag_i`  in  32  SoC completion flag; any nonzero value means done.
- `mem_result_i`  in  32  SoC result word.
- `error_i`  in  1  the same fault-injection strobe that drives SoC `error`.
- `fetch_enable_o`  out  1  connects to SoC `fetch_enable_i`.
- `done_o`  out  1  verdict valid.
- `pass_o`  out  1  flag seen and result equals expected.
- `timeout_o`  out  1  timeout verdict.
- `stall_o`  out  1  lockup verdict.
- `result_o`  out  32  latched `mem_result_i`.
- `cycles_o`  out  32  number of RUN cycles elapsed.
- `fault_cnt_o`  out  ERR_CNT_W  count of `error_i` rising edges during RUN; saturates.

## Operation
- FSM with three states: IDLE, RUN, DONE. Reset puts it in IDLE and forces every output to 0.
- IDLE: `fetch_enable_o`=0. `start_i` moves to RUN and clears `cycles_o`, `fault_cnt_o`, the stall counter, `result_o`, and all verdict bits.
- RUN: `fetch_enable_o`=1. On every edge:
  - `cycles_o` increments, saturating at 2^32−1.
  - `last_addr` takes `instr_addr_i`.
  - `stall_cnt` increments when `instr_addr_i==last_addr` and clears otherwise.
- Termination is evaluated in every RUN cycle, in priority order:
  1. `mem_flag_i!=0`: latch `result_o=mem_result_i` and set `pass_o=(mem_result_i==expected_i)`.
  2. Else, if the address is unchanged and `stall_cnt==STALL_CYCLES-1`: set `stall_o`.
  3. Else, if `cycles_o==TIMEOUT_CYCLES-1` before the increment: set `timeout_o`.
  
  Any of these sets `done_o` and moves to DONE.
- A failing result gives `done_o`=1 with `pass_o`, `timeout_o`, and `stall_o` all 0.
- Fault counting: a registered copy `err_q` of `error_i` is updated in every state. In RUN, `error_i & ~err_q` increments `fault_cnt_o`, saturating at 2^ERR_CNT_W−1.
- DONE: `fetch_enable_o`=0 and all outputs hold. `start_i` restarts exactly as from IDLE.
- Simultaneous events:
  - flag and stall/timeout in the same cycle gives a flag verdict.
  - An error edge in the terminating cycle is counted.
  - `start_i` in RUN has no effect.
- Reset mid-run: the synchronous reset returns the block to IDLE with all outputs at 0 on the next edge. No verdict is produced.

## Timing
- All outputs are registered.
- `fetch_enable_o` rises on the edge that samples `start_i`.
- The verdict, `done_o`, and latched values appear on the edge that samples the terminating condition, i.e. one cycle after the SoC presents `mem_flag_i`.
- `cycles_o` at done equals the 1-based index of the RUN cycle in which the condition was sampled. A timeout therefore reports exactly `TIMEOUT_CYCLES`.
- A stall is declared on the `STALL_CYCLES`-th consecutive equal comparison. The first comparison in a run is against the address captured on the previous edge.
- `fetch_enable_o` falls on the same edge that `done_o` rises.

## Test plan
- Bench parameters: `TIMEOUT_CYCLES`=100, `STALL_CYCLES`=8.
- Normal pass: start; address increments by 4 per cycle; at RUN cycle 30 drive `mem_flag_i`=1, `mem_result_i`=55, `expected_i`=55. Next edge: `done_o`=1, `pass_o`=1, `result_o`=55, `cycles_o`=30, `fetch_enable_o`=0.
- Wrong result: same as normal pass but `mem_result_i`=54. Required: `done_o`=1, `pass_o`=0, `timeout_o`=0, `stall_o`=0, `result_o`=54.
- Stall: address increments, then is frozen at 0x40 from RUN cycle 10. Required: `stall_o`=1 after 8 equal comparisons, `cycles_o`=17, `pass_o`=0.
- Timeout with faults: address always increments, flag never set; pulse `error_i` for 2 cycles at RUN cycle 10 and for 2 cycles at RUN cycle 60. Required: `timeout_o`=1, `cycles_o`=100, `fault_cnt_o`=2.
- Priority and reset: flag asserted in RUN cycle 100 gives a flag verdict with `timeout_o`=0. Separately, `rst_ni`=0 at RUN cycle 20 gives all outputs 0 and IDLE on the next edge, and a later `start_i` gives a clean run with `cycles_o` restarting from 1.
